// File: rtl/register_wb_arbiter_if.sv
// Writeback bus between the two pipeline requesters, the register file and the stall table.
// Handshake: a requester raises rN_valid with reg/size/data stable and holds them until
// rN_ready is high in the same cycle; valid never depends on ready; the beat transfers on that edge.
interface register_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 3
);
    logic              r0_valid;
    logic              r0_ready;
    logic              r0_lock;
    logic [REG_W-1:0]  r0_reg;
    logic [1:0]        r0_size;
    logic [DATA_W-1:0] r0_data;

    logic              r1_valid;
    logic              r1_ready;
    logic              r1_lock;
    logic [REG_W-1:0]  r1_reg;
    logic [1:0]        r1_size;
    logic [DATA_W-1:0] r1_data;

    logic              rf_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_reg;
    logic [1:0]        rf_size;
    logic [DATA_W-1:0] rf_data;
    logic [REG_W-1:0]  wb_reg;
    logic              wb_is_valid;

    modport master (
        output r0_valid, r0_lock, r0_reg, r0_size, r0_data,
        input  r0_ready,
        output r1_valid, r1_lock, r1_reg, r1_size, r1_data,
        input  r1_ready,
        output rf_stall,
        input  rf_we, rf_reg, rf_size, rf_data, wb_reg, wb_is_valid
    );

    modport slave (
        input  r0_valid, r0_lock, r0_reg, r0_size, r0_data,
        output r0_ready,
        input  r1_valid, r1_lock, r1_reg, r1_size, r1_data,
        output r1_ready,
        input  rf_stall,
        output rf_we, rf_reg, rf_size, rf_data, wb_reg, wb_is_valid
    );
endinterface

// File: rtl/register_wb_arbiter.sv
// Round-robin arbiter (with per-requester lock) sharing the register file write port
// between two writeback requesters; the registered winner also clears the stall table entry.
module register_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 3
) (
    input  logic                clk,
    input  logic                reset,
    register_wb_arbiter_if.slave bus,
    output logic [1:0]          dbg_lock_own,
    output logic                dbg_prio
);

    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_R0   = 2'd1,
        LOCK_R1   = 2'd2
    } lock_own_t;

    lock_own_t         lock_q, lock_d;
    logic              prio_q, prio_d;
    logic              grant0, grant1;

    logic              we_q;
    logic [REG_W-1:0]  reg_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] data_q;

    // Grants are gated by reset so neither requester sees ready while the block is held in reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        lock_d = lock_q;
        prio_d = prio_q;
        if (reset && !bus.rf_stall) begin
            case (lock_q)
                LOCK_R0: grant0 = bus.r0_valid;
                LOCK_R1: grant1 = bus.r1_valid;
                default: begin
                    if (bus.r0_valid && bus.r1_valid) begin
                        grant0 = !prio_q;
                        grant1 = prio_q;
                    end else begin
                        grant0 = bus.r0_valid;
                        grant1 = bus.r1_valid;
                    end
                end
            endcase
        end
        if (grant0) begin
            prio_d = 1'b1;
            lock_d = bus.r0_lock ? LOCK_R0 : LOCK_NONE;
        end else if (grant1) begin
            prio_d = 1'b0;
            lock_d = bus.r1_lock ? LOCK_R1 : LOCK_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lock_q <= LOCK_NONE;
            prio_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            prio_q <= prio_d;
        end
    end

    // A stalled register file freezes the pending write so it is retried, not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q   <= 1'b0;
            reg_q  <= '0;
            size_q <= '0;
            data_q <= '0;
        end else if (!bus.rf_stall) begin
            if (grant0) begin
                we_q   <= 1'b1;
                reg_q  <= bus.r0_reg;
                size_q <= bus.r0_size;
                data_q <= bus.r0_data;
            end else if (grant1) begin
                we_q   <= 1'b1;
                reg_q  <= bus.r1_reg;
                size_q <= bus.r1_size;
                data_q <= bus.r1_data;
            end else begin
                we_q   <= 1'b0;
            end
        end
    end

    assign bus.r0_ready    = grant0;
    assign bus.r1_ready    = grant1;
    assign bus.rf_we       = we_q;
    assign bus.rf_reg      = reg_q;
    assign bus.rf_size     = size_q;
    assign bus.rf_data     = data_q;
    assign bus.wb_is_valid = we_q;
    assign bus.wb_reg      = reg_q;

    assign dbg_lock_own    = lock_q;
    assign dbg_prio        = prio_q;

endmodule

// File: tb/tb_register_wb_arbiter.sv
// Directed bench for register_wb_arbiter: per-scenario tasks check handshakes inline,
// and a negedge monitor checks every committed write against the expected queue.
module tb_register_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int REG_W  = 3;
    localparam int EXP_W  = REG_W + 2 + DATA_W;

    logic clk;
    logic reset;
    logic [1:0] dbg_lock_own;
    logic       dbg_prio;

    int checks = 0;
    int errors = 0;

    logic [EXP_W-1:0] exp_q[$];

    register_wb_arbiter_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

    register_wb_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .dbg_lock_own (dbg_lock_own),
        .dbg_prio     (dbg_prio)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 200000)", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    // A write is committed to the register file at a rising edge with rf_we=1 and rf_stall=0.
    always @(negedge clk) begin
        logic [EXP_W-1:0] got;
        logic [EXP_W-1:0] exp;
        if (reset && bus.rf_we && !bus.rf_stall) begin
            got = {bus.rf_reg, bus.rf_size, bus.rf_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got write %h, expected none", got);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL sb_write: got %h, expected %h", got, exp);
                end
            end
            checks++;
            if (bus.wb_reg !== bus.rf_reg || bus.wb_is_valid !== 1'b1) begin
                errors++;
                $display("FAIL sb_wb_clear: got wb_reg=%0d wb_is_valid=%b, expected %0d/1",
                         bus.wb_reg, bus.wb_is_valid, bus.rf_reg);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r0(input logic v, input logic lk, input logic [REG_W-1:0] r,
                            input logic [1:0] s, input logic [DATA_W-1:0] d);
        bus.r0_valid = v;
        bus.r0_lock  = lk;
        bus.r0_reg   = r;
        bus.r0_size  = s;
        bus.r0_data  = d;
    endtask

    task automatic drive_r1(input logic v, input logic lk, input logic [REG_W-1:0] r,
                            input logic [1:0] s, input logic [DATA_W-1:0] d);
        bus.r1_valid = v;
        bus.r1_lock  = lk;
        bus.r1_reg   = r;
        bus.r1_size  = s;
        bus.r1_data  = d;
    endtask

    task automatic idle();
        drive_r0(1'b0, 1'b0, '0, 2'b00, '0);
        drive_r1(1'b0, 1'b0, '0, 2'b00, '0);
        bus.rf_stall = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        reset = 1'b0;
        drive_r0(1'b1, 1'b0, 3'd5, 2'b10, 32'h1234_5678);
        drive_r1(1'b1, 1'b0, 3'd6, 2'b10, 32'h8765_4321);
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if ({bus.rf_we, bus.wb_is_valid, bus.r0_ready, bus.r1_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got we/wbv/rdy0/rdy1=%b, expected 0000",
                     {bus.rf_we, bus.wb_is_valid, bus.r0_ready, bus.r1_ready});
        end
        checks++;
        if (bus.rf_reg !== 3'd0 || bus.wb_reg !== 3'd0 || bus.rf_size !== 2'd0 || bus.rf_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got reg=%0d wb_reg=%0d size=%0d data=%h, expected all 0",
                     bus.rf_reg, bus.wb_reg, bus.rf_size, bus.rf_data);
        end
        checks++;
        if (dbg_lock_own !== 2'd0 || dbg_prio !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got lock_own=%0d prio=%b, expected 0/0", dbg_lock_own, dbg_prio);
        end
        idle();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_contention();
        logic exp_r0;
        drive_r0(1'b1, 1'b0, 3'd1, 2'b10, 32'h1111_1111);
        drive_r1(1'b1, 1'b0, 3'd2, 2'b10, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            exp_r0 = (i % 2 == 0);
            @(negedge clk);
            checks++;
            if (bus.r0_ready !== exp_r0 || bus.r1_ready !== !exp_r0) begin
                errors++;
                $display("FAIL contention_grant[%0d]: got rdy0=%b rdy1=%b, expected %b/%b",
                         i, bus.r0_ready, bus.r1_ready, exp_r0, !exp_r0);
            end
            if (exp_r0) exp_q.push_back({3'd1, 2'b10, 32'h1111_1111});
            else        exp_q.push_back({3'd2, 2'b10, 32'h2222_2222});
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_r0_only();
        drive_r0(1'b1, 1'b0, 3'd3, 2'b10, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL r0_only_ready: got rdy0=%b rdy1=%b, expected 1/0", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd3, 2'b10, 32'hDEAD_BEEF});
        tick();
        idle();
        checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_reg !== 3'd3 || bus.rf_data !== 32'hDEAD_BEEF ||
            bus.wb_is_valid !== 1'b1 || bus.wb_reg !== 3'd3) begin
            errors++;
            $display("FAIL r0_only_latency: got we=%b reg=%0d data=%h wbv=%b wb_reg=%0d, expected 1/3/deadbeef/1/3",
                     bus.rf_we, bus.rf_reg, bus.rf_data, bus.wb_is_valid, bus.wb_reg);
        end
        tick();
        checks++;
        if (bus.rf_we !== 1'b0 || bus.wb_is_valid !== 1'b0) begin
            errors++;
            $display("FAIL r0_only_pulse: got we=%b wbv=%b, expected 0/0", bus.rf_we, bus.wb_is_valid);
        end
    endtask

    // prio points at r1 on entry, so r1 wins first and then holds the port via lock.
    task automatic test_lock();
        drive_r0(1'b1, 1'b0, 3'd7, 2'b01, 32'h0000_7777);
        drive_r1(1'b1, 1'b1, 3'd4, 2'b10, 32'h4444_4444);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_first: got rdy0=%b rdy1=%b, expected 0/1", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd4, 2'b10, 32'h4444_4444});
        tick();
        drive_r1(1'b1, 1'b0, 3'd5, 2'b10, 32'h5555_5555);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL lock_held: got rdy0=%b rdy1=%b, expected 0/1", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd5, 2'b10, 32'h5555_5555});
        tick();
        drive_r1(1'b0, 1'b0, '0, 2'b00, '0);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL lock_release: got rdy0=%b rdy1=%b, expected 1/0", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd7, 2'b01, 32'h0000_7777});
        tick();
        idle();
        tick();
    endtask

    task automatic test_stall();
        drive_r0(1'b1, 1'b0, 3'd6, 2'b10, 32'h6666_6666);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_accept: got rdy0=%b, expected 1", bus.r0_ready);
        end
        exp_q.push_back({3'd6, 2'b10, 32'h6666_6666});
        tick();
        drive_r0(1'b0, 1'b0, '0, 2'b00, '0);
        drive_r1(1'b1, 1'b0, 3'd2, 2'b00, 32'h0000_00AB);
        bus.rf_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rf_we !== 1'b1 || bus.rf_reg !== 3'd6 || bus.r1_ready !== 1'b0 || bus.r0_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got we=%b reg=%0d rdy0=%b rdy1=%b, expected 1/6/0/0",
                         i, bus.rf_we, bus.rf_reg, bus.r0_ready, bus.r1_ready);
            end
            tick();
        end
        bus.rf_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: got rdy1=%b, expected 1", bus.r1_ready);
        end
        exp_q.push_back({3'd2, 2'b00, 32'h0000_00AB});
        tick();
        idle();
        tick();
    endtask

    // Lock survives a gap in r0_valid; reserved size 11 passes through untouched.
    task automatic test_lock_persist();
        drive_r0(1'b1, 1'b1, 3'd1, 2'b11, 32'hCAFE_0001);
        @(negedge clk);
        exp_q.push_back({3'd1, 2'b11, 32'hCAFE_0001});
        tick();
        drive_r0(1'b0, 1'b0, '0, 2'b00, '0);
        drive_r1(1'b1, 1'b0, 3'd2, 2'b01, 32'hCAFE_0002);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.r1_ready !== 1'b0 || dbg_lock_own !== 2'd1) begin
                errors++;
                $display("FAIL persist_block[%0d]: got rdy1=%b lock_own=%0d, expected 0/1",
                         i, bus.r1_ready, dbg_lock_own);
            end
            tick();
        end
        drive_r0(1'b1, 1'b0, 3'd3, 2'b00, 32'hCAFE_0003);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL persist_unlock: got rdy0=%b rdy1=%b, expected 1/0", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd3, 2'b00, 32'hCAFE_0003});
        tick();
        drive_r0(1'b0, 1'b0, '0, 2'b00, '0);
        @(negedge clk);
        checks++;
        if (bus.r1_ready !== 1'b1) begin
            errors++;
            $display("FAIL persist_other: got rdy1=%b, expected 1", bus.r1_ready);
        end
        exp_q.push_back({3'd2, 2'b01, 32'hCAFE_0002});
        tick();
        idle();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [REG_W-1:0]  r;
        logic [1:0]        s;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 8; i++) begin
            r = REG_W'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            d = $urandom();
            drive_r1(1'b1, 1'b0, r, s, d);
            @(negedge clk);
            checks++;
            if (bus.r1_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: got rdy1=%b, expected 1", i, bus.r1_ready);
            end
            exp_q.push_back({r, s, d});
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        drive_r0(1'b1, 1'b0, 3'd2, 2'b10, 32'hBAD0_BAD0);
        @(negedge clk);
        tick();
        idle();
        checks++;
        if (bus.rf_we !== 1'b1 || dbg_prio !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got we=%b prio=%b, expected 1/1", bus.rf_we, dbg_prio);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rf_we !== 1'b0 || bus.wb_is_valid !== 1'b0 || dbg_prio !== 1'b0) begin
            errors++;
            $display("FAIL areset_clear: got we=%b wbv=%b prio=%b, expected 0/0/0",
                     bus.rf_we, bus.wb_is_valid, dbg_prio);
        end
        void'(exp_q.pop_front());
        tick();
        reset = 1'b1;
        tick();
        drive_r0(1'b1, 1'b0, 3'd4, 2'b10, 32'h0000_0A0A);
        drive_r1(1'b1, 1'b0, 3'd5, 2'b10, 32'h0000_0B0B);
        @(negedge clk);
        checks++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            errors++;
            $display("FAIL areset_prio: got rdy0=%b rdy1=%b, expected 1/0", bus.r0_ready, bus.r1_ready);
        end
        exp_q.push_back({3'd4, 2'b10, 32'h0000_0A0A});
        tick();
        idle();
        repeat (2) tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        idle();
        #2;
        test_reset();
        test_contention();
        test_r0_only();
        test_lock();
        test_stall();
        test_lock_persist();
        test_back_to_back();
        test_async_reset();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d writes outstanding, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
